// File: rtl/sobel_packet_tx_pkg.sv
// sobel_packet_tx_pkg
// Shared types and constants for the Sobel transmit-side packer.
//   PCIEPacket   : host-bound word; this block drives only .valid and .data
//   PCIE_DATA_W  : packet payload width in bits
//   PIX_W        : width of one edge-magnitude pixel
//   pack_state_t : pack FSM states (EMPTY = no pixels held, FILL = partial word)
package sobel_packet_tx_pkg;

  localparam int PCIE_DATA_W = 512;
  localparam int PIX_W       = 8;

  typedef struct packed {
    logic                   valid;
    logic [PCIE_DATA_W-1:0] data;
  } PCIEPacket;

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } pack_state_t;

endpackage

// File: rtl/sobel_packet_tx_fifo.sv
// packet_fifo
// Synchronous first-word-fall-through FIFO holding completed packet words.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   push, push_data : write request and entry to store
//   pop             : consume the head entry
//   head            : current head entry (all zeros while empty)
//   full, empty     : occupancy flags
//   count           : number of stored entries, 0..DEPTH
module packet_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Requests are ignored when they cannot be honoured, so a stray push or
  // pop never corrupts the occupancy count.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // Zeroed head while empty keeps the output word quiet when nothing is queued.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sobel_packet_tx.sv
// sobel_packet_tx
// Packs a stream of 8-bit edge magnitudes into 512-bit packet words and
// queues them for the host DMA.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   pix_valid/ready : pixel handshake, pix_data is the magnitude,
//                     pix_last marks the final pixel of a frame
//   pcie_packet_out : head word (.valid present, .data pixels, pixel 0 in LSB)
//   out_last        : head word closes a frame
//   out_bytes       : number of meaningful bytes in the head word, 1..64
//   out_ready       : host accepts the head word
//   words_sent      : words handed to the host (wraps)
//   frames_done     : words handed over with out_last set (wraps)
module sobel_packet_tx
  import sobel_packet_tx_pkg::*;
#(
  parameter int PIX_PER_WORD = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_last,
  output logic                  pix_ready,
  output PCIEPacket             pcie_packet_out,
  output logic                  out_last,
  output logic [6:0]            out_bytes,
  input  logic                  out_ready,
  output logic [31:0]           words_sent,
  output logic [15:0]           frames_done
);

  localparam int IDX_W  = $clog2(PIX_PER_WORD);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = PCIE_DATA_W + 1 + 7;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(PIX_PER_WORD - 1);

  pack_state_t            state;
  pack_state_t            state_next;
  logic [PCIE_DATA_W-1:0] acc;
  logic [PCIE_DATA_W-1:0] next_word;
  logic [IDX_W-1:0]       idx;
  logic                   accept;
  logic                   word_done;
  logic                   push;
  logic                   pop;
  logic [ENTRY_W-1:0]     fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [PCIE_DATA_W-1:0] head_data;

  // Ready only when a whole word could be queued, so the pixel that
  // completes a word never finds the FIFO full.
  assign pix_ready = !rst && (fifo_count < DEPTH_CNT);
  assign accept    = pix_valid && pix_ready;

  // Word under construction including the pixel on the bus this cycle.
  // Starting from zero in EMPTY guarantees unfilled bytes read as zero.
  always_comb begin
    next_word = (state == EMPTY) ? '0 : acc;
    next_word[idx*PIX_W +: PIX_W] = pix_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A word closes on the last byte slot or on an end-of-frame pixel,
  // whichever comes first; either way the FSM goes back to EMPTY.
  always_comb begin
    state_next = state;
    word_done  = 1'b0;
    push       = 1'b0;
    if (accept) begin
      word_done = pix_last || (idx == LAST_SLOT);
      push      = word_done && !fifo_full;
      case (state)
        EMPTY:   state_next = word_done ? EMPTY : FILL;
        FILL:    state_next = word_done ? EMPTY : FILL;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      if (word_done) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= next_word;
        idx <= idx + 1'b1;
      end
    end
  end

  packet_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({next_word, pix_last, 7'(idx) + 7'd1}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_data, out_last, out_bytes} = fifo_head;
  assign pcie_packet_out.valid = !fifo_empty;
  assign pcie_packet_out.data  = head_data;
  assign pop = !fifo_empty && out_ready;

  // Counters advance on the same edge the host takes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_sent  <= '0;
      frames_done <= '0;
    end else if (pop) begin
      words_sent <= words_sent + 32'd1;
      if (out_last) frames_done <= frames_done + 16'd1;
    end
  end

endmodule

// File: doc/sobel_packet_tx.md
# sobel_packet_tx

Transmit-side packer that closes the loop of the Sobel datapath. It accepts the per-pixel 8-bit edge-magnitude stream produced behind `sobel_unit` and packs it into 512-bit `PCIEPacket` words for return to the host. Flow control is valid/ready on the pixel side and a ready input from the host DMA on the packet side. A small output FIFO decouples the two sides.

## Interface
Parameters:
- `PIX_PER_WORD`, default 64: pixels per packet word, each 8 bits; `PIX_PER_WORD*8` must equal the `PCIEPacket` data width.
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `pix_valid`  in  1  pixel present.
- `pix_data`  in  8  edge magnitude.
- `pix_last`  in  1  last pixel of frame; qualified by `pix_valid`.
- `pix_ready`  out  1  pixel accepted when `pix_valid & pix_ready`.
- `pcie_packet_out`  out  `PCIEPacket`  packed word; `.valid` marks presence, `.data` carries the pixels.
- `out_last`  out  1  word ends a frame.
- `out_bytes`  out  7  valid bytes in word, 1..64.
- `out_ready`  in  1  host/DMA accepts the word when `.valid & out_ready`.
- `words_sent`  out  32  count of words handed off.
- `frames_done`  out  16  count of frames completed at output.

## Operation
- Accumulator: a 512-bit register plus a 6-bit byte index `idx`. The k-th accepted pixel of a word goes to `data[8k+7:8k]`, so pixel 0 occupies the LSB byte. Unfilled bytes are zero.
- Pack FSM:
  - EMPTY (idx=0). First accepted pixel moves the FSM to FILL.
  - FILL (1≤idx≤63). A word completes on the 64th accepted pixel or on any accepted pixel with `pix_last`. On completion the word, `out_last=pix_last` and `out_bytes=idx+1` are pushed into the FIFO, and the FSM returns to EMPTY.
  - From EMPTY, a single accepted pixel with `pix_last` pushes a 1-byte word.
- `pix_last` on the 64th pixel produces exactly one word with `out_last=1` and `out_bytes=64`. No empty trailing word is ever produced.
- `pix_ready = (fifo_count < FIFO_DEPTH)`. This is conservative: a completing pixel always has room.
- FIFO head drives the outputs. `.valid = !fifo_empty`. Pop on `.valid & out_ready`.
- While `.valid & !out_ready`, `data`, `out_last` and `out_bytes` hold stable.
- Push and pop in the same cycle leave the count unchanged. A push into a full FIFO is impossible by construction; the bench asserts this.
- `words_sent` increments on every pop. `frames_done` increments on every pop with `out_last=1`. Both wrap modulo 2^32 and 2^16.
- Reset, including mid-frame:
  - Discards the partial accumulator and the FIFO contents.
  - Zeroes `idx` and both counters.
  - FSM returns to EMPTY.
  - `pix_ready` is 0 during reset and 1 the cycle after.

## Timing
- Reset values:
  - `pcie_packet_out.valid=0`, `.data=0`.
  - `out_last=0`, `out_bytes=0`.
  - `words_sent=0`, `frames_done=0`.
  - `pix_ready=0` while `rst` is high.
- Latency: the completing pixel is accepted at edge N. With the FIFO previously empty, `.valid` is high in the cycle after edge N.
- Sustained throughput: 1 pixel/cycle when `out_ready` stays high, i.e. one word every 64 cycles.
- `pix_ready` deasserts in the cycle after the FIFO becomes full. It reasserts in the cycle after a pop.
- Counters update on the edge of the pop handshake.

## Structure
- Shared package:
  - `PCIEPacket` type (existing; this block uses `.valid` and `.data` only).
  - `PCIE_DATA_W=512`.
  - `PIX_W=8`.
  - Pack-FSM state enum `pack_state_t` {EMPTY, FILL}.
- One sub-module, `packet_fifo`: a synchronous FIFO of {data, last, bytes}, with full/empty/count outputs and first-word-fall-through head.
- Top level holds the accumulator, the FSM and the counters.

## Test plan
- 128 pixels with values 0..127 contiguous, `pix_last` on pixel 127, `out_ready=1`:
  - Two words: word 0 has byte k=k, `out_bytes=64`, `out_last=0`; word 1 has byte k=64+k, `out_bytes=64`, `out_last=1`.
  - `words_sent=2`, `frames_done=1`.
- 10 pixels 0xA0..0xA9, `pix_last` on the 10th:
  - One word, bytes 0..9 = 0xA0..0xA9, bytes 10..63 = 0, `out_bytes=10`, `out_last=1`.
- Single pixel 0xFF with `pix_last` from EMPTY:
  - Word `data=0xFF`, `out_bytes=1`.
- `out_ready=0` while streaming 320 pixels:
  - After 4 words `pix_ready` drops.
  - Head word stays stable.
  - On releasing `out_ready`, all 5 words emerge in order with no loss or duplication.
- Assert `rst` for 1 cycle after 30 pixels of a frame, then send 64 pixels of a new frame:
  - First output word contains only the new pixels.
  - Counters restart at 0, then read `words_sent=1`.
- Simultaneous push and pop with the FIFO at depth 3 for 200 cycles:
  - Count stays at 3.
  - `pix_ready` never drops.
